// File: rtl/sign_ext_pkg.sv
// +--------------------------------------------------------------------+
// | sign_ext_pkg: shared LEGv8 widths, opcodes and immediate formats   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package sign_ext_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DATA_W  = 64;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_D    = 2'd1,
    FMT_CB   = 2'd2
  } imm_fmt_t;

endpackage : sign_ext_pkg

`default_nettype wire

// File: rtl/sign_ext_comb.sv
// +--------------------------------------------------------------------+
// | sign_ext_comb: opcode decode and immediate sign extension          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sign_ext_comb
  import sign_ext_pkg::*;
(
  input  logic [INSTR_W-1:0] a,
  output logic [DATA_W-1:0]  y,
  output imm_fmt_t           fmt
);

  // Low five bits belong to no supported immediate field.
  logic w_unused_ok;
  assign w_unused_ok = ^a[4:0];

  always_comb begin
    y   = '0;
    fmt = FMT_NONE;
    if ((a[31:21] == OP_LDUR) || (a[31:21] == OP_STUR)) begin
      y   = {{55{a[20]}}, a[20:12]};
      fmt = FMT_D;
    end else if (a[31:24] == OP_CBZ) begin
      y   = {{45{a[23]}}, a[23:5]};
      fmt = FMT_CB;
    end
  end

endmodule : sign_ext_comb

`default_nettype wire

// File: rtl/sign_ext.sv
// +--------------------------------------------------------------------+
// | sign_ext: combinational immediate extender with registered copy    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sign_ext
  import sign_ext_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] a,
  output logic [DATA_W-1:0]  y,
  output logic [1:0]         fmt,
  output logic [DATA_W-1:0]  y_q,
  output logic [1:0]         fmt_q
);

  logic [DATA_W-1:0] y_d;
  imm_fmt_t          fmt_d;

  sign_ext_comb u_comb (
    .a   (a),
    .y   (y_d),
    .fmt (fmt_d)
  );

  assign y   = y_d;
  assign fmt = fmt_d;

  // Reset only touches the pipeline copy; the combinational path stays live.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q   <= '0;
      fmt_q <= 2'b00;
    end else begin
      y_q   <= y_d;
      fmt_q <= fmt_d;
    end
  end

endmodule : sign_ext

`default_nettype wire

// File: tb/tb_sign_ext.sv
// +--------------------------------------------------------------------+
// | tb_sign_ext: directed scoreboard bench for sign_ext                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sign_ext;

  logic        clk;
  logic        reset_n;
  logic [31:0] a;
  logic [63:0] y;
  logic [1:0]  fmt;
  logic [63:0] y_q;
  logic [1:0]  fmt_q;

  int n_cmp;
  int n_fail;

  logic [65:0] sb[$];

  sign_ext dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .y       (y),
    .fmt     (fmt),
    .y_q     (y_q),
    .fmt_q   (fmt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference built from arithmetic shifts rather than bit replication.
  function automatic logic [65:0] model(input logic [31:0] ai);
    logic signed [63:0] t;
    if ((ai[31:21] == 11'h7C2) || (ai[31:21] == 11'h7C0)) begin
      t = {ai[20:12], 55'd0};
      t = t >>> 55;
      return {2'd1, t};
    end else if (ai[31:24] == 8'hB4) begin
      t = {ai[23:5], 45'd0};
      t = t >>> 45;
      return {2'd2, t};
    end
    return 66'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, check the combinational path, then the registered copy.
  task automatic step(input string tag, input logic [31:0] ai, input logic [63:0] exp_y,
                      input logic [1:0] exp_fmt);
    logic [65:0] e;
    @(negedge clk);
    a = ai;
    #1;
    chk({tag, ".y"}, y, exp_y);
    chk({tag, ".fmt"}, {62'd0, fmt}, {62'd0, exp_fmt});
    sb.push_back(model(ai));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".y_q"}, y_q, e[63:0]);
      chk({tag, ".fmt_q"}, {62'd0, fmt_q}, {62'd0, e[65:64]});
    end
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    a       = {11'h7C2, 9'h1FF, 12'h0};

    // Registered outputs pinned at zero through clock edges while in reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.y_q", y_q, 64'd0);
    chk("rst.fmt_q", {62'd0, fmt_q}, 64'd0);
    chk("rst.y_comb", y, ONES);
    chk("rst.fmt_comb", {62'd0, fmt}, 64'd1);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel.y_q_before_edge", y_q, 64'd0);
    chk("rel.y_comb", y, ONES);
    @(posedge clk);
    #1;
    chk("rel.y_q_after_edge", y_q, ONES);
    chk("rel.fmt_q_after_edge", {62'd0, fmt_q}, 64'd1);

    step("ldur_neg",   {11'h7C2, 9'h1FF, 12'h000},  ONES,                   2'd1);
    step("ldur_pos",   {11'h7C2, 9'h0FF, 12'h000},  64'h0000_0000_0000_00FF, 2'd1);
    step("ldur_min",   {11'h7C2, 9'h100, 12'h000},  64'hFFFF_FFFF_FFFF_FF00, 2'd1);
    step("stur_neg",   {11'h7C0, 9'h1FF, 12'h000},  ONES,                   2'd1);
    step("stur_pos",   {11'h7C0, 9'h0FF, 12'h000},  64'h0000_0000_0000_00FF, 2'd1);
    step("cbz_neg",    {8'hB4, 19'h7FFFF, 5'h00},   ONES,                   2'd2);
    step("cbz_pos",    {8'hB4, 19'h3FFFF, 5'h00},   64'h0000_0000_0003_FFFF, 2'd2);
    step("cbz_min",    {8'hB4, 19'h40000, 5'h00},   64'hFFFF_FFFF_FFFC_0000, 2'd2);
    step("none_one",   32'h0000_0001,               64'd0,                  2'd0);
    step("ldur_junk",  {11'h7C2, 9'h0FF, 12'hABC},  64'h0000_0000_0000_00FF, 2'd1);
    step("cbz_junk",   {8'hB4, 19'h3FFFF, 5'h1F},   64'h0000_0000_0003_FFFF, 2'd2);
    step("cbnz",       {8'hB5, 19'h7FFFF, 5'h00},   64'd0,                  2'd0);
    step("near_ldur",  {11'h7C1, 9'h1FF, 12'h000},  64'd0,                  2'd0);
    step("near_stur",  {11'h7C4, 9'h1FF, 12'hFFF},  64'd0,                  2'd0);
    step("ldur_again", {11'h7C2, 9'h1FF, 12'h000},  ONES,                   2'd1);

    // Mid-cycle reset: clears registers with no clock edge, combinational path untouched.
    @(posedge clk);
    #2;
    chk("async.pre_y_q", y_q, ONES);
    reset_n = 1'b0;
    #1;
    chk("async.y_q", y_q, 64'd0);
    chk("async.fmt_q", {62'd0, fmt_q}, 64'd0);
    chk("async.y_comb", y, ONES);
    sb.delete();
    @(negedge clk);
    a = {8'hB4, 19'h3FFFF, 5'h0};
    @(posedge clk);
    #1;
    chk("async.held_y_q", y_q, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("async.rel_y_comb", y, 64'h0000_0000_0003_FFFF);
    chk("async.rel_fmt_comb", {62'd0, fmt}, 64'd2);
    step("post_rst_cbz", {8'hB4, 19'h3FFFF, 5'h00}, 64'h0000_0000_0003_FFFF, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sign_ext

`default_nettype wire
